spike_isi_buffer: RTL and testbench

Downstream consumer of the leaky integrate-and-fire neuron's `spike` output. Detects spike onsets, measures the inter-spike interval (ISI) in clock cycles, and queues each interval in a small FIFO. Intervals drain over a valid/ready interface toward readout logic on the output pins. Provides a sticky overflow flag when intervals are dropped.

---
 rtl/spike_isi_buffer.sv | 104 ++++++++++
 tb/tb_spike_isi_buffer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_isi_buffer.sv
// Inter-spike interval capture for the LIF neuron's spike output.
// Measures cycles between spike onsets and queues them in a small FIFO drained via valid/ready.
module spike_isi_buffer #(
  parameter int ISI_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     spike_in,
  input  logic                     en,
  output logic [ISI_W-1:0]         isi_out,
  output logic                     isi_valid,
  input  logic                     isi_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ISI_W-1:0] IVL_MAX  = '1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {
    IDLE,
    ARMED
  } state_t;

  state_t             state, state_nxt;
  logic               prev;
  logic [ISI_W-1:0]   ivl, ivl_nxt, ivl_inc;
  logic               onset;
  logic               push_try, push, pop, drop, full;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [ISI_W-1:0]   mem [DEPTH];

  // prev tracks spike_in even while disabled, so enabling mid-pulse is not an onset.
  assign onset   = spike_in & ~prev & en;
  assign ivl_inc = (ivl == IVL_MAX) ? ivl : ivl + 1'b1;

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    ivl_nxt   = ivl;
    push_try  = 1'b0;
    case (state)
      IDLE: begin
        if (onset) begin
          state_nxt = ARMED;
          ivl_nxt   = '0;
        end
      end
      ARMED: begin
        if (onset) begin
          push_try = 1'b1;
          ivl_nxt  = '0;
        end else if (en) begin
          ivl_nxt = ivl_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign full      = (count == FULL_CNT);
  assign isi_valid = (count != '0);
  assign pop       = isi_valid & isi_ready;
  // A same-cycle pop frees the slot, so a full FIFO can still accept.
  assign push      = push_try & (~full | pop);
  assign drop      = push_try & full & ~pop;
  assign isi_out   = isi_valid ? mem[rd_ptr] : '0;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ivl      <= '0;
      prev     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      ivl   <= ivl_nxt;
      prev  <= spike_in;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  // NOTE: storage is deliberately not reset; count gates what is visible at isi_out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ivl_inc;
  end

endmodule

// File: tb/tb_spike_isi_buffer.sv
// Scoreboard bench for spike_isi_buffer: directed scenarios plus randomized traffic
// checked against an interval model that counts enabled cycles between onsets.
module tb_spike_isi_buffer;

  localparam int ISI_W = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SAT   = (1 << ISI_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             spike_in = 1'b0;
  logic             en = 1'b1;
  logic             isi_ready = 1'b0;
  logic             clr_ovf = 1'b0;
  logic [ISI_W-1:0] isi_out;
  logic             isi_valid;
  logic [CNT_W-1:0] count;
  logic             overflow;

  spike_isi_buffer #(.ISI_W(ISI_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .spike_in  (spike_in),
    .en        (en),
    .isi_out   (isi_out),
    .isi_valid (isi_valid),
    .isi_ready (isi_ready),
    .count     (count),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  int sb[$];
  int got_log[$];
  int exp_q[$];

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: interval = number of enabled cycles after the reference onset
  // up to and including the next onset, saturated. FIFO modelled as an occupancy count.
  bit m_prev, m_armed, m_ovf;
  int m_ivl, m_count;

  always @(posedge clk) begin
    bit ev, popm, push_try, drop;
    int val;
    if (reset) begin
      m_prev = 0; m_armed = 0; m_ivl = 0; m_count = 0; m_ovf = 0;
      sb.delete();
    end else begin
      ev       = spike_in && !m_prev && en;
      m_prev   = spike_in;
      popm     = (m_count > 0) && isi_ready;
      push_try = 0;
      val      = 0;
      if (en) begin
        if (!m_armed) begin
          if (ev) begin m_armed = 1; m_ivl = 0; end
        end else begin
          m_ivl++;
          if (ev) begin
            push_try = 1;
            val = (m_ivl > SAT) ? SAT : m_ivl;
            m_ivl = 0;
          end
        end
      end
      drop = push_try && (m_count == DEPTH) && !popm;
      if (push_try && !drop) sb.push_back(val);
      m_count = m_count + ((push_try && !drop) ? 1 : 0) - (popm ? 1 : 0);
      if (drop) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
    end
  end

  // Monitor: sampled mid-cycle; a valid&ready seen here transfers at the next edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("count", int'(count), m_count);
      check("overflow", int'(overflow), int'(m_ovf));
      check("valid", int'(isi_valid), int'(m_count > 0));
      if (isi_valid) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL data: got %0d expected no entry at %0t", isi_out, $time);
        end else begin
          check("data", int'(isi_out), sb[0]);
          if (isi_ready && !reset) begin
            got_log.push_back(int'(isi_out));
            void'(sb.pop_front());
          end
        end
      end else begin
        check("out_zero", int'(isi_out), 0);
      end
    end
  end

  task automatic cyc(bit s);
    spike_in = s;
    @(posedge clk);
    #1;
  endtask

  task automatic gap(int g);
    for (int i = 0; i < g - 1; i++) cyc(1'b0);
    cyc(1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b1; clr_ovf = 1'b0;
    cyc(1'b0);
    cyc(1'b0);
    reset = 1'b0;
    got_log.delete();
  endtask

  task automatic drain();
    isi_ready = 1'b1;
    for (int i = 0; i < 40 && m_count != 0; i++) cyc(1'b0);
    cyc(1'b0);
    check("drain_count", int'(count), 0);
  endtask

  task automatic check_log(string name);
    check({name, "_len"}, got_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_log.size(); i++)
      check(name, got_log[i], exp_q[i]);
  endtask

  initial begin
    #1;
    cyc(1'b0);
    reset = 1'b0;
    mon_en = 1'b1;

    // Basic intervals with one-cycle latency.
    do_reset();
    isi_ready = 1'b1;
    cyc(1'b1);
    check("ref_no_push", int'(isi_valid), 0);
    gap(5);
    check("lat_valid", int'(isi_valid), 1);
    check("lat_out", int'(isi_out), 5);
    gap(10);
    check("lat_out2", int'(isi_out), 10);
    drain();
    exp_q = '{5, 10};
    check_log("basic");

    // Sustained high counts once.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b0);
    cyc(1'b1);
    drain();
    exp_q = '{10};
    check_log("held");

    // Saturation then short interval.
    do_reset();
    cyc(1'b1);
    gap(400);
    gap(3);
    drain();
    exp_q = '{SAT, 3};
    check_log("sat");

    // Overflow with stalled consumer.
    do_reset();
    isi_ready = 1'b0;
    cyc(1'b1);
    for (int g = 4; g <= 9; g++) gap(g);
    cyc(1'b0);
    check("full_count", int'(count), 4);
    check("ovf_set", int'(overflow), 1);
    drain();
    exp_q = '{4, 5, 6, 7};
    check_log("ovf");
    clr_ovf = 1'b1;
    cyc(1'b0);
    clr_ovf = 1'b0;
    check("ovf_clr", int'(overflow), 0);

    // Push into a full FIFO with a same-cycle pop.
    do_reset();
    isi_ready = 1'b0;
    cyc(1'b1);
    for (int i = 0; i < 4; i++) gap(3);
    cyc(1'b0);
    cyc(1'b0);
    isi_ready = 1'b1;
    cyc(1'b1);
    isi_ready = 1'b0;
    check("pp_count", int'(count), 4);
    check("pp_ovf", int'(overflow), 0);
    drain();
    exp_q = '{3, 3, 3, 3, 3};
    check_log("pushpop");

    // Enable gating, and enabling while spike_in is already high.
    do_reset();
    isi_ready = 1'b1;
    cyc(1'b1);
    cyc(1'b0);
    en = 1'b0;
    for (int i = 0; i < 8; i++) cyc(1'b0);
    cyc(1'b1);
    for (int i = 0; i < 9; i++) cyc(1'b0);
    en = 1'b1;
    gap(6);
    en = 1'b0;
    cyc(1'b0);
    cyc(1'b1);
    cyc(1'b1);
    en = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b1);
    cyc(1'b0);
    cyc(1'b1);
    drain();
    exp_q = '{7, 5};
    check_log("enable");

    // Reset mid-operation discards queue and reference spike.
    isi_ready = 1'b0;
    gap(3);
    gap(4);
    check("pre_rst_count", int'(count), 2);
    reset = 1'b1;
    cyc(1'b0);
    reset = 1'b0;
    check("rst_valid", int'(isi_valid), 0);
    check("rst_count", int'(count), 0);
    cyc(1'b1);
    cyc(1'b0);
    check("rst_no_ref", int'(count), 0);
    gap(4);
    check("rst_next", int'(count), 1);
    drain();

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      en        = ($urandom_range(0, 99) < 85);
      isi_ready = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 25 : 70));
      clr_ovf   = ($urandom_range(0, 99) < 4);
      reset     = ($urandom_range(0, 399) == 0);
      cyc($urandom_range(0, 99) < 35);
    end
    reset = 1'b0;
    clr_ovf = 1'b0;
    en = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
